// File: rtl/alu_check_ctrl.sv
// Operand-entry and result-check controller: builds A/B/E from CHUNK-bit switch loads, captures ALU result/flags, compares against E.
// Latency: load/capture edge in cycle n visible in n+1; auto sequence done two cycles after the final E chunk load edge.
// Backpressure: none; strobes are level inputs edge-detected internally, loads during EXEC are dropped.
module alu_check_ctrl #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    localparam int NCHUNK = WIDTH / CHUNK,
    localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CHUNK-1:0] src,
    input  logic             load,
    input  logic             capture,
    input  logic             mode,
    input  logic [CW+1:0]    sel,
    input  logic [1:0]       disp_sel,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] exp_out,
    output logic [WIDTH-1:0] result_q,
    output logic [3:0]       flags_q,
    output logic             match,
    output logic             done,
    output logic             busy,
    output logic [CW+1:0]    ptr,
    output logic [WIDTH-1:0] disp_word
);

    typedef enum logic [1:0] {IDLE, LOAD, EXEC, DONE} state_t;

    localparam logic [1:0]    TGT_A    = 2'd0;
    localparam logic [1:0]    TGT_B    = 2'd1;
    localparam logic [1:0]    TGT_E    = 2'd2;
    localparam logic [CW-1:0] LAST_IDX = CW'(NCHUNK - 1);

    state_t        state_q, state_d;
    logic [CW+1:0] ptr_d;
    logic          load_prev, cap_prev, mode_prev;
    logic          load_edge, cap_edge;
    logic          wr_en, cap_en;
    logic [1:0]    wr_tgt;
    logic [CW-1:0] wr_idx;

    assign load_edge = load & ~load_prev;
    assign cap_edge  = capture & ~cap_prev;
    assign busy      = (state_q == LOAD) || (state_q == EXEC);
    assign done      = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr     <= '0;
        end else begin
            state_q <= state_d;
            ptr     <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr;
        wr_en   = 1'b0;
        cap_en  = 1'b0;
        wr_tgt  = sel[CW+1:CW];
        wr_idx  = sel[CW-1:0];
        if (mode != mode_prev) begin
            state_d = IDLE;
            ptr_d   = '0;
        end else if (!mode) begin
            state_d = IDLE;
            wr_en   = load_edge;
            cap_en  = cap_edge;
        end else begin
            case (state_q)
                EXEC: begin
                    cap_en  = 1'b1;
                    state_d = DONE;
                end
                default: begin
                    // A load out of DONE restarts the entry at A/0 regardless of ptr
                    wr_tgt = (state_q == DONE) ? TGT_A : ptr[CW+1:CW];
                    wr_idx = (state_q == DONE) ? '0 : ptr[CW-1:0];
                    if (load_edge) begin
                        wr_en   = 1'b1;
                        state_d = LOAD;
                        if (wr_idx != LAST_IDX) begin
                            ptr_d = {wr_tgt, wr_idx + 1'b1};
                        end else if (wr_tgt != TGT_E) begin
                            ptr_d = {wr_tgt + 2'd1, {CW{1'b0}}};
                        end else begin
                            ptr_d   = '0;
                            state_d = EXEC;
                        end
                    end
                end
            endcase
        end
    end

    // Strobe history keeps sampling through reset so a held strobe gives no edge on release
    always_ff @(posedge clk) begin
        load_prev <= load;
        cap_prev  <= capture;
        mode_prev <= mode;
        if (rst) begin
            a_out    <= '0;
            b_out    <= '0;
            exp_out  <= '0;
            result_q <= '0;
            flags_q  <= '0;
            match    <= 1'b0;
        end else begin
            if (cap_en) begin
                result_q <= alu_result;
                flags_q  <= alu_flags;
                match    <= (alu_result == exp_out);
            end
            if (wr_en && (int'(wr_idx) < NCHUNK)) begin
                case (wr_tgt)
                    TGT_A:   a_out[int'(wr_idx)*CHUNK +: CHUNK]   <= src;
                    TGT_B:   b_out[int'(wr_idx)*CHUNK +: CHUNK]   <= src;
                    TGT_E:   exp_out[int'(wr_idx)*CHUNK +: CHUNK] <= src;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        disp_word = a_out;
        case (disp_sel)
            2'd1:    disp_word = b_out;
            2'd2:    disp_word = result_q;
            2'd3:    disp_word = exp_out;
            default: disp_word = a_out;
        endcase
    end

endmodule
